// File: rtl/noc_output_port_arbiter.sv
// Round-robin packet-level allocator for one router output port, with wormhole lock and credit tracking.
// Optional stall watchdog enabled by defining NOC_ARB_WATCHDOG_EN.
module noc_output_port_arbiter #(
  parameter int unsigned NUM_INPUTS = 5,
  parameter int unsigned CREDITS    = 4,
  parameter int unsigned WDT_LIMIT  = 256
) (
  input  logic                           noc_clk,
  input  logic                           noc_rst_n,
  input  logic [NUM_INPUTS-1:0]          request,
  input  logic [NUM_INPUTS-1:0]          end_of_packet,
  input  logic                           flit_fire,
  input  logic                           credit_return,
  output logic [NUM_INPUTS-1:0]          grant,
  output logic [$clog2(NUM_INPUTS)-1:0]  grant_idx,
  output logic                           locked,
  output logic                           flit_allow,
  output logic [$clog2(CREDITS+1)-1:0]   credit_cnt,
  output logic                           credit_err,
  output logic                           wdt_release
);

  localparam int unsigned IDX_W = $clog2(NUM_INPUTS);
  localparam int unsigned CNT_W = $clog2(CREDITS+1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t                  state, state_nxt;
  logic [NUM_INPUTS-1:0]   grant_nxt;
  logic [IDX_W-1:0]        grant_idx_nxt;
  logic [IDX_W-1:0]        rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]        winner;
  logic                    found;
  logic                    tail_fire;
  logic                    wdt_hit;
  logic [IDX_W-1:0]        owner_next;
  int unsigned             scan;

  // Scan starts at rr_ptr and wraps; the first requester seen wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    scan   = 0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      scan = (32'(rr_ptr) + k) % NUM_INPUTS;
      if (!found && request[scan]) begin
        found  = 1'b1;
        winner = IDX_W'(scan);
      end
    end
  end

  assign tail_fire  = flit_fire && end_of_packet[grant_idx];
  assign owner_next = (grant_idx == IDX_W'(NUM_INPUTS-1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    grant_idx_nxt = grant_idx;
    rr_ptr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt     = LOCKED;
          grant_nxt     = NUM_INPUTS'(1) << winner;
          grant_idx_nxt = winner;
        end
      end
      LOCKED: begin
        if (tail_fire || wdt_hit) begin
          state_nxt  = IDLE;
          grant_nxt  = '0;
          rr_ptr_nxt = owner_next;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      grant_idx <= grant_idx_nxt;
      rr_ptr    <= rr_ptr_nxt;
    end
  end

  assign locked     = (state == LOCKED);
  assign flit_allow = locked && (credit_cnt != '0);

  // Simultaneous fire and return cancel, but a fire at zero is still an error.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      credit_cnt <= CNT_W'(CREDITS);
      credit_err <= 1'b0;
    end else begin
      case ({flit_fire, credit_return})
        2'b10: begin
          if (credit_cnt == '0) credit_err <= 1'b1;
          else                  credit_cnt <= credit_cnt - 1'b1;
        end
        2'b01: begin
          if (credit_cnt == CNT_W'(CREDITS)) credit_err <= 1'b1;
          else                               credit_cnt <= credit_cnt + 1'b1;
        end
        2'b11: begin
          if (credit_cnt == '0) credit_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef NOC_ARB_WATCHDOG_EN
  localparam int unsigned WDT_W = $clog2(WDT_LIMIT+1);

  logic [WDT_W-1:0] wdt_cnt;

  // Fires on the stalled cycle that would bring the count to WDT_LIMIT.
  assign wdt_hit = (state == LOCKED) && !flit_fire && (wdt_cnt == WDT_W'(WDT_LIMIT-1));

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      wdt_cnt     <= '0;
      wdt_release <= 1'b0;
    end else begin
      wdt_release <= wdt_hit;
      if (state != LOCKED || flit_fire || wdt_hit) wdt_cnt <= '0;
      else                                         wdt_cnt <= wdt_cnt + 1'b1;
    end
  end
`else
  assign wdt_hit     = 1'b0;
  assign wdt_release = 1'b0;
`endif

endmodule

// File: tb/tb_noc_output_port_arbiter.sv
// Scoreboard bench for noc_output_port_arbiter: a cycle model queues expected outputs per driven cycle.
// Covers the watchdog path when NOC_ARB_WATCHDOG_EN is defined.
module tb_noc_output_port_arbiter;

  localparam int N   = 5;
  localparam int CR  = 4;
  localparam int WDT = 8;

  logic         noc_clk;
  logic         noc_rst_n;
  logic [N-1:0] request;
  logic [N-1:0] end_of_packet;
  logic         flit_fire;
  logic         credit_return;
  logic [N-1:0] grant;
  logic [2:0]   grant_idx;
  logic         locked;
  logic         flit_allow;
  logic [2:0]   credit_cnt;
  logic         credit_err;
  logic         wdt_release;

  noc_output_port_arbiter #(
    .NUM_INPUTS(N),
    .CREDITS(CR),
    .WDT_LIMIT(WDT)
  ) dut (
    .noc_clk(noc_clk),
    .noc_rst_n(noc_rst_n),
    .request(request),
    .end_of_packet(end_of_packet),
    .flit_fire(flit_fire),
    .credit_return(credit_return),
    .grant(grant),
    .grant_idx(grant_idx),
    .locked(locked),
    .flit_allow(flit_allow),
    .credit_cnt(credit_cnt),
    .credit_err(credit_err),
    .wdt_release(wdt_release)
  );

  initial noc_clk = 1'b0;
  always #5 noc_clk = ~noc_clk;

  typedef struct {
    logic [N-1:0] grant;
    int           idx;
    logic         locked;
    logic         allow;
    int           cnt;
    logic         err;
    logic         wdtp;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  logic         m_locked;
  logic [N-1:0] m_grant;
  int           m_idx;
  int           m_rr;
  int           m_cnt;
  logic         m_err;
  int           m_wdt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_grant  = '0;
    m_idx    = 0;
    m_rr     = 0;
    m_cnt    = CR;
    m_err    = 1'b0;
    m_wdt    = 0;
    sb_q.delete();
  endtask

  task automatic model_next(input logic [N-1:0] req, input logic [N-1:0] eop,
                            input logic fire, input logic cret, output exp_t e);
    logic rel;
    logic wp;
    rel = 1'b0;
    wp  = 1'b0;
    if (!m_locked) begin
      m_wdt = 0;
      if (req != '0) begin
        for (int k = 0; k < N; k++) begin
          if (req[(m_rr + k) % N]) begin
            m_idx = (m_rr + k) % N;
            break;
          end
        end
        m_locked = 1'b1;
        m_grant  = N'(1) << m_idx;
      end
    end else begin
      if (fire && eop[m_idx]) rel = 1'b1;
`ifdef NOC_ARB_WATCHDOG_EN
      else if (fire) m_wdt = 0;
      else if (m_wdt + 1 == WDT) begin
        rel = 1'b1;
        wp  = 1'b1;
      end else m_wdt = m_wdt + 1;
`endif
      if (rel) begin
        m_locked = 1'b0;
        m_grant  = '0;
        m_rr     = (m_idx + 1) % N;
        m_wdt    = 0;
      end
    end
    if (fire && !cret) begin
      if (m_cnt == 0) m_err = 1'b1;
      else            m_cnt = m_cnt - 1;
    end else if (cret && !fire) begin
      if (m_cnt == CR) m_err = 1'b1;
      else             m_cnt = m_cnt + 1;
    end else if (fire && cret && m_cnt == 0) begin
      m_err = 1'b1;
    end
    e.grant  = m_grant;
    e.idx    = m_idx;
    e.locked = m_locked;
    e.allow  = m_locked && (m_cnt != 0);
    e.cnt    = m_cnt;
    e.err    = m_err;
    e.wdtp   = wp;
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check_eq("grant", 32'(grant), 32'(e.grant));
    check_eq("locked", 32'(locked), 32'(e.locked));
    if (e.locked) check_eq("grant_idx", 32'(grant_idx), 32'(e.idx));
    check_eq("flit_allow", 32'(flit_allow), 32'(e.allow));
    check_eq("credit_cnt", 32'(credit_cnt), 32'(e.cnt));
    check_eq("credit_err", 32'(credit_err), 32'(e.err));
    check_eq("wdt_release", 32'(wdt_release), 32'(e.wdtp));
  endtask

  task automatic step(input logic [N-1:0] req, input logic [N-1:0] eop,
                      input logic fire, input logic cret);
    exp_t e;
    request       = req;
    end_of_packet = eop;
    flit_fire     = fire;
    credit_return = cret;
    model_next(req, eop, fire, cret, e);
    sb_q.push_back(e);
    @(posedge noc_clk);
    #1;
    compare_out();
  endtask

  task automatic do_reset();
    request       = '0;
    end_of_packet = '0;
    flit_fire     = 1'b0;
    credit_return = 1'b0;
    noc_rst_n     = 1'b0;
    model_reset();
    repeat (2) @(posedge noc_clk);
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
    @(posedge noc_clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    noc_rst_n     = 1'b0;
    request       = '0;
    end_of_packet = '0;
    flit_fire     = 1'b0;
    credit_return = 1'b0;
    do_reset();

    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_locked", 32'(locked), 32'h0);
    check_eq("rst_credit", 32'(credit_cnt), 32'd4);
    check_eq("rst_err", 32'(credit_err), 32'h0);
    check_eq("rst_allow", 32'(flit_allow), 32'h0);
    check_eq("rst_wdt", 32'(wdt_release), 32'h0);

    // Single requester on input 2
    step(5'b00100, '0, 1'b0, 1'b0);
    check_eq("first_grant", 32'(grant), 32'b00100);
    check_eq("first_idx", 32'(grant_idx), 32'd2);
    check_eq("first_locked", 32'(locked), 32'd1);
    check_eq("first_credit", 32'(credit_cnt), 32'd4);
    step(5'b00100, 5'b00100, 1'b1, 1'b1);

    // All inputs request single-flit packets: strict rotation with a bubble
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(5'b11111, '0, 1'b0, 1'b0);
      check_eq("rr_order", 32'(grant_idx), 32'(i % N));
      step(5'b11111, 5'b11111, 1'b1, 1'b1);
      check_eq("bubble", 32'(locked), 32'd0);
    end

    // Three-flit packet from owner 1 while 0 and 3 wait
    do_reset();
    step(5'b00010, '0, 1'b0, 1'b0);
    step(5'b01011, 5'b01001, 1'b1, 1'b1);
    check_eq("hold_1", 32'(grant), 32'b00010);
    step(5'b01011, 5'b01001, 1'b1, 1'b1);
    check_eq("hold_2", 32'(grant), 32'b00010);
    step(5'b01011, 5'b01011, 1'b1, 1'b1);
    check_eq("tail_rel", 32'(locked), 32'd0);
    step(5'b01001, '0, 1'b0, 1'b0);
    check_eq("next_owner", 32'(grant_idx), 32'd3);

    // Credit exhaustion, then fire+return at zero
    do_reset();
    step(5'b00001, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(5'b00001, '0, 1'b1, 1'b0);
    check_eq("cred_zero", 32'(credit_cnt), 32'd0);
    check_eq("allow_zero", 32'(flit_allow), 32'd0);
    check_eq("err_before", 32'(credit_err), 32'd0);
    step(5'b00001, '0, 1'b1, 1'b1);
    check_eq("cred_still0", 32'(credit_cnt), 32'd0);
    check_eq("err_fire0", 32'(credit_err), 32'd1);

    // Overflow, then asynchronous reset mid-packet
    do_reset();
    step('0, '0, 1'b0, 1'b1);
    check_eq("ovf_cnt", 32'(credit_cnt), 32'd4);
    check_eq("ovf_err", 32'(credit_err), 32'd1);
    step(5'b00100, '0, 1'b0, 1'b0);
    step(5'b00100, '0, 1'b1, 1'b0);
    request       = '0;
    flit_fire     = 1'b0;
    credit_return = 1'b0;
    noc_rst_n     = 1'b0;
    #1;
    check_eq("midrst_grant", 32'(grant), 32'h0);
    check_eq("midrst_locked", 32'(locked), 32'h0);
    check_eq("midrst_cnt", 32'(credit_cnt), 32'd4);
    check_eq("midrst_err", 32'(credit_err), 32'h0);
    model_reset();
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
    @(posedge noc_clk);
    #1;

    // Stalled lock: forced release with the watchdog, held forever without it
    do_reset();
    step(5'b00110, '0, 1'b0, 1'b0);
    check_eq("wdt_owner", 32'(grant_idx), 32'd1);
`ifdef NOC_ARB_WATCHDOG_EN
    for (int i = 0; i < WDT; i++) step(5'b00110, '0, 1'b0, 1'b0);
    check_eq("wdt_pulse", 32'(wdt_release), 32'd1);
    check_eq("wdt_grant", 32'(grant), 32'h0);
    step(5'b00110, '0, 1'b0, 1'b0);
    check_eq("wdt_pulse_end", 32'(wdt_release), 32'd0);
    check_eq("wdt_rr", 32'(grant_idx), 32'd2);
`else
    for (int i = 0; i < 3 * WDT; i++) step(5'b00110, '0, 1'b0, 1'b0);
    check_eq("nowdt_locked", 32'(locked), 32'd1);
    check_eq("nowdt_grant", 32'(grant), 32'b00010);
    check_eq("nowdt_pulse", 32'(wdt_release), 32'd0);
`endif

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(N'($urandom), N'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
